// File: rtl/rx_iq_pkg.sv
// Shared constants, FSM state type and lane helpers for the RX I/Q packer.
package rx_iq_pkg;

  localparam logic MODE_2R2T = 1'b0;
  localparam logic MODE_1R1T = 1'b1;

  localparam int SAMPLE_W = 12;
  localparam int LANE_W   = 16;
  localparam int WORD_W   = 4 * LANE_W;

  // Bit offsets of the four 16-bit lanes inside a packed word.
  localparam int LANE_D1_LO = 0;
  localparam int LANE_Q1_LO = 16;
  localparam int LANE_D2_LO = 32;
  localparam int LANE_Q2_LO = 48;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WAIT_A = 2'd1,
    ST_WAIT_B = 2'd2
  } state_t;

  // Sign-extend one 12-bit two's-complement sample to a 16-bit lane.
  function automatic logic [LANE_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
    return {{(LANE_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/rx_iq_fifo.sv
// Synchronous first-word-fall-through FIFO. A write while full is accepted
// only when a read happens in the same cycle.
module rx_iq_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     wr_ack,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ack;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign wr_ack  = wr_en && (!full || rd_en);
  assign rd_ack  = rd_en && !empty;
  // Head entry is presented directly; zero when empty so reset clears the bus.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; emptiness is tracked by the pointers
  // and level, so clearing the RAM would only cost logic and block RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_ack) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking.
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ack) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ack) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ack, rd_ack})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rx_iq_packer.sv
// Packs ADC I/Q samples into 64-bit AXI-Stream words (2R2T: one sample per
// channel per word; 1R1T: two consecutive ch1 samples per word), buffers them
// in a FWFT FIFO and marks every PKT_LEN-th accepted word with tlast.
module rx_iq_packer
  import rx_iq_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_LEN    = 256
) (
  input  logic                          data_clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          phy_mode,
  input  logic                          adc_d1q1_valid,
  input  logic                          adc_d2q2_valid,
  input  logic [SAMPLE_W-1:0]           adc_data_d1,
  input  logic [SAMPLE_W-1:0]           adc_data_q1,
  input  logic [SAMPLE_W-1:0]           adc_data_d2,
  input  logic [SAMPLE_W-1:0]           adc_data_q2,
  input  logic                          m_axis_tready,
  input  logic                          ovf_clr,
  output logic [WORD_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  state_t              state, next_state;
  logic                cap1, cap2, cap_any;
  logic                mode_q, mode_chg;
  logic [2*LANE_W-1:0] low_half, cur_lo, hi_half;
  logic                store_low, word_wr, word_cur_lo, fsm_drop;
  logic [WORD_W-1:0]   word;
  logic [CNT_W-1:0]    wcnt;
  logic                tlast_in;
  logic                fifo_full, fifo_empty, wr_ack, rd_en, fifo_drop;
  logic [16:0]         drop_sum;
  logic [1:0]          drop_inc;

  // Strobes lead their data by one cycle; delay them to line up with data.
  always_ff @(posedge data_clk) begin
    if (!rst_n) begin
      cap1   <= 1'b0;
      cap2   <= 1'b0;
      mode_q <= MODE_2R2T;
    end else begin
      cap1   <= adc_d1q1_valid;
      cap2   <= adc_d2q2_valid;
      mode_q <= phy_mode;
    end
  end

  assign cap_any  = cap1 | cap2;
  assign mode_chg = (phy_mode != mode_q);

  // FSM state register.
  always_ff @(posedge data_clk) begin
    if (!rst_n) state <= ST_OFF;
    else        state <= next_state;
  end

  // Next-state and datapath control. Simultaneous ch1+ch2 in 2R2T is treated
  // as ch1 arriving first, so the pair completes a word in one cycle.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    next_state  = state;
    store_low   = 1'b0;
    word_wr     = 1'b0;
    word_cur_lo = 1'b0;
    fsm_drop    = 1'b0;
    if (!enable) begin
      next_state = ST_OFF;
    end else if (state == ST_OFF || mode_chg) begin
      next_state = ST_WAIT_A;
    end else if (phy_mode == MODE_1R1T) begin
      if (cap_any) begin
        if (state == ST_WAIT_A) begin
          store_low  = 1'b1;
          next_state = ST_WAIT_B;
        end else begin
          word_wr    = 1'b1;
          next_state = ST_WAIT_A;
        end
      end
    end else begin
      case (state)
        ST_WAIT_A: begin
          if (cap1 && cap2) begin
            word_wr     = 1'b1;
            word_cur_lo = 1'b1;
          end else if (cap1) begin
            store_low  = 1'b1;
            next_state = ST_WAIT_B;
          end else if (cap2) begin
            fsm_drop = 1'b1;
          end
        end
        ST_WAIT_B: begin
          if (cap1 && cap2) begin
            word_wr     = 1'b1;
            word_cur_lo = 1'b1;
            fsm_drop    = 1'b1;
            next_state  = ST_WAIT_A;
          end else if (cap2) begin
            word_wr    = 1'b1;
            next_state = ST_WAIT_A;
          end else if (cap1) begin
            store_low = 1'b1;
            fsm_drop  = 1'b1;
          end
        end
        default: next_state = ST_OFF;
      endcase
    end
  end

  assign cur_lo  = {sext(adc_data_q1), sext(adc_data_d1)};
  assign hi_half = (phy_mode == MODE_1R1T) ? cur_lo
                                           : {sext(adc_data_q2), sext(adc_data_d2)};
  assign word    = {hi_half, word_cur_lo ? cur_lo : low_half};

  // Low half of the word being assembled.
  always_ff @(posedge data_clk) begin
    if (!rst_n)         low_half <= '0;
    else if (store_low) low_half <= cur_lo;
  end

  // Packet word counter: advances only on accepted writes, cleared when idle.
  always_ff @(posedge data_clk) begin
    if (!rst_n || !enable) begin
      wcnt <= '0;
    end else if (wr_ack) begin
      if (tlast_in) wcnt <= '0;
      else          wcnt <= wcnt + 1'b1;
    end
  end

  assign tlast_in = (wcnt == CNT_W'(PKT_LEN - 1));
  assign rd_en    = m_axis_tvalid & m_axis_tready;

  rx_iq_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (data_clk),
    .rst_n   (rst_n),
    .wr_en   (word_wr),
    .wr_data ({tlast_in, word}),
    .rd_en   (rd_en),
    .rd_data ({m_axis_tlast, m_axis_tdata}),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .wr_ack  (wr_ack),
    .level   (fifo_level)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign fifo_drop     = word_wr & fifo_full & ~rd_en;
  assign drop_inc      = {1'b0, fsm_drop} + {1'b0, fifo_drop};
  assign drop_sum      = {1'b0, drop_cnt} + 17'(drop_inc);

  // Sticky overflow flag and saturating drop counter; clear wins.
  always_ff @(posedge data_clk) begin
    if (!rst_n || ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (fifo_drop) overflow <= 1'b1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_rx_iq_packer.sv
// Scoreboard bench for rx_iq_packer: stimulus pushes expected words, a
// negedge monitor pops and compares every handshaked output word.
module tb_rx_iq_packer;

  logic        data_clk = 1'b0;
  logic        rst_n, enable, phy_mode;
  logic        adc_d1q1_valid, adc_d2q2_valid;
  logic [11:0] adc_data_d1, adc_data_q1, adc_data_d2, adc_data_q2;
  logic        m_axis_tready, ovf_clr;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, overflow;
  logic [15:0] drop_cnt;
  logic [4:0]  fifo_level;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 data_clk = ~data_clk;

  rx_iq_packer #(.FIFO_DEPTH(16), .PKT_LEN(4)) dut (
    .data_clk       (data_clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .phy_mode       (phy_mode),
    .adc_d1q1_valid (adc_d1q1_valid),
    .adc_d2q2_valid (adc_d2q2_valid),
    .adc_data_d1    (adc_data_d1),
    .adc_data_q1    (adc_data_q1),
    .adc_data_d2    (adc_data_d2),
    .adc_data_q2    (adc_data_q2),
    .m_axis_tready  (m_axis_tready),
    .ovf_clr        (ovf_clr),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .fifo_level     (fifo_level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshaked beat must match the head of the scoreboard.
  always @(negedge data_clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %h with nothing expected", m_axis_tdata);
      end else begin
        mon_e = sb.pop_front();
        check("tdata", m_axis_tdata, mon_e.data);
        check("tlast", 64'(m_axis_tlast), 64'(mon_e.last));
      end
    end
  end

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic push(input logic last, input logic [63:0] data);
    beat_t b;
    b.last = last;
    b.data = data;
    sb.push_back(b);
  endtask

  task automatic send_ch1(input logic [11:0] d, input logic [11:0] q);
    adc_d1q1_valid = 1'b1;
    tick();
    adc_d1q1_valid = 1'b0;
    adc_data_d1 = d;
    adc_data_q1 = q;
    tick();
  endtask

  task automatic send_ch2(input logic [11:0] d, input logic [11:0] q);
    adc_d2q2_valid = 1'b1;
    tick();
    adc_d2q2_valid = 1'b0;
    adc_data_d2 = d;
    adc_data_q2 = q;
    tick();
  endtask

  // 2R2T word number k: d1=k, q1=0x100+k, d2=0x200+k, q2=0x800|k (negative).
  task automatic send_word(input int k);
    logic [11:0] k12;
    k12 = 12'(k);
    send_ch1(k12, 12'h100 + k12);
    send_ch2(12'h200 + k12, 12'h800 | k12);
  endtask

  function automatic logic [63:0] word_exp(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {16'hF800 | kk, 16'h0200 + kk, 16'h0100 + kk, kk};
  endfunction

  task automatic restart_packet();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; phy_mode = 1'b0;
    adc_d1q1_valid = 1'b0; adc_d2q2_valid = 1'b0;
    adc_data_d1 = '0; adc_data_q1 = '0; adc_data_d2 = '0; adc_data_q2 = '0;
    m_axis_tready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();

    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);

    rst_n = 1'b1; enable = 1'b1; m_axis_tready = 1'b1;
    tick();

    // 2R2T sign extension and lane order; one-cycle tvalid pulse.
    push(1'b0, 64'hFFFF_0001_07FF_F801);
    send_ch1(12'h801, 12'h7FF);
    send_ch2(12'h001, 12'hFFF);
    check("first_tvalid", 64'(m_axis_tvalid), 64'd1);
    tick();
    check("tvalid_one_cycle", 64'(m_axis_tvalid), 64'd0);

    // 1R1T: two ch1 samples per word.
    phy_mode = 1'b1;
    tick();
    push(1'b0, 64'h0008_0007_0006_0005);
    send_ch1(12'd5, 12'd6);
    send_ch1(12'd7, 12'd8);
    tick();

    // 2R2T orphan ch2, ch1, replacing ch1, ch2.
    phy_mode = 1'b0;
    tick();
    push(1'b0, 64'h0666_0555_0444_FA00);
    send_ch2(12'h0AA, 12'h0BB);
    send_ch1(12'h111, 12'h222);
    send_ch1(12'hA00, 12'h444);
    send_ch2(12'h555, 12'h666);
    tick();
    check("orphan_drop_cnt", 64'(drop_cnt), 64'd2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr_drop_cnt", 64'(drop_cnt), 64'd0);

    // Packet boundaries with PKT_LEN=4: tlast on words 4 and 8 of 9.
    restart_packet();
    for (int k = 0; k < 9; k++) begin
      push((k == 3) || (k == 7), word_exp(k));
      send_word(k);
    end
    repeat (4) tick();

    // Backpressure: 17 words into a 16-deep FIFO.
    restart_packet();
    m_axis_tready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (k < 16) push((k == 3) || (k == 7) || (k == 11) || (k == 15), word_exp(32 + k));
      send_word(32 + k);
    end
    tick();
    check("full_level", 64'(fifo_level), 64'd16);
    check("full_overflow", 64'(overflow), 64'd1);
    check("full_drop_cnt", 64'(drop_cnt), 64'd1);
    check("stall_tdata_hold", m_axis_tdata, word_exp(32));
    tick();
    check("stall_tdata_hold2", m_axis_tdata, word_exp(32));
    m_axis_tready = 1'b1;
    for (int i = 0; i < 100 && fifo_level != 0; i++) tick();
    check("drain_level", 64'(fifo_level), 64'd0);

    // Reset with 3 words queued and half a word pending.
    restart_packet();
    m_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) send_word(64 + k);
    send_ch1(12'h123, 12'h456);
    rst_n = 1'b0;
    tick();
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_tdata", m_axis_tdata, 64'd0);
    check("midrst_tlast", 64'(m_axis_tlast), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("midrst_level", 64'(fifo_level), 64'd0);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    repeat (10) tick();
    check("post_rst_level", 64'(fifo_level), 64'd0);
    push(1'b0, word_exp(80));
    send_word(80);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("final_level", 64'(fifo_level), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_iq_packer.md
RX_IQ_PACKER -- requirements
Module: rx_iq_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2, >=4).
REQ-002 Parameter PKT_LEN, default 256, words per output packet (tlast period, >=1).
REQ-003 data_clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 enable  in  1  packing enable.
REQ-006 phy_mode  in  1  0 = 2R2T, 1 = 1R1T.
REQ-007 adc_d1q1_valid  in  1  channel-1 sample strobe.
REQ-008 adc_d2q2_valid  in  1  channel-2 sample strobe.
REQ-009 adc_data_d1, adc_data_q1, adc_data_d2, adc_data_q2  in  12 each  two's-complement I/Q samples.
REQ-010 m_axis_tready  in  1  downstream ready.
REQ-011 ovf_clr  in  1  clears overflow and drop_cnt.
REQ-012 m_axis_tdata  out  64  packed word.
REQ-013 m_axis_tvalid  out  1  word valid.
REQ-014 m_axis_tlast  out  1  last word of packet.
REQ-015 overflow  out  1  sticky FIFO-full drop flag.
REQ-016 drop_cnt  out  16  dropped words/samples, saturating.
REQ-017 fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Strobes lead data by one cycle: a sample SHALL be captured from adc_data_* on the cycle after its strobe.
REQ-019 Each 12-bit sample SHALL be sign-extended to 16 bits.
REQ-020 2R2T word layout SHALL be [15:0]=d1, [31:16]=q1, [47:32]=d2, [63:48]=q2.
REQ-021 1R1T word layout SHALL be [15:0]=d1, [31:16]=q1 of the first sample, and [47:32]=d1, [63:48]=q1 of the second sample.
REQ-022 The FSM SHALL have states OFF, WAIT_A, WAIT_B; enable=0 forces OFF; enable=1 in OFF goes to WAIT_A.
REQ-023 In WAIT_A, a captured sample (ch1 in 2R2T, any in 1R1T) SHALL be stored as the low half, then go to WAIT_B.
REQ-024 In WAIT_B, a captured ch2 (2R2T) or next sample (1R1T) SHALL complete the word, issue a FIFO write, then go to WAIT_A.
REQ-025 2R2T ch2 capture in WAIT_A SHALL be discarded with drop_cnt+1.
REQ-026 2R2T ch1 capture in WAIT_B SHALL overwrite the low half with drop_cnt+1.
REQ-027 A phy_mode change or enable deassertion SHALL discard any partial word without counting it and return to WAIT_A (or OFF).
REQ-028 The FIFO SHALL store {tlast, tdata}.
REQ-029 tlast SHALL be 1 on every PKT_LEN-th accepted word.
REQ-030 The word counter SHALL advance only on accepted writes and reset to 0 when enable=0.
REQ-031 A write when full and not simultaneously read SHALL be dropped, set overflow, and increment drop_cnt.
REQ-032 A write when full with a simultaneous read SHALL be accepted.
REQ-033 A read SHALL occur on m_axis_tvalid & m_axis_tready.
REQ-034 m_axis_tvalid SHALL equal FIFO non-empty.
REQ-035 First-word latency SHALL be 1 cycle from write to m_axis_tvalid.
REQ-036 m_axis_tdata and m_axis_tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-037 The FIFO SHALL continue draining while enable=0.
REQ-038 drop_cnt SHALL saturate at 16'hFFFF.
REQ-039 ovf_clr SHALL take priority over a same-cycle increment or overflow set.

Reset
REQ-040 rst_n=0 SHALL place the FSM in OFF and empty the FIFO.
REQ-041 rst_n=0 SHALL force m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, overflow=0, drop_cnt=0, fifo_level=0, and word counter=0.
REQ-042 Reset asserted mid-packet SHALL lose all pending data, with no tvalid on the cycle after reset sampled low.

Structure
REQ-043 Package rx_iq_pkg SHALL hold the MODE_2R2T/MODE_1R1T constants, the FSM state enum, SAMPLE_W=12, LANE_W=16, and the lane bit offsets.
REQ-044 The FIFO SHALL be sub-module rx_iq_fifo (synchronous, first-word-fall-through, parameterised width/depth).

Verification
REQ-045 2R2T: ch1 d1=12'h801, q1=12'h7FF, then ch2 d2=1, q2=12'hFFF, with tready=1 -> tdata=64'hFFFF_0001_07FF_F801 and tvalid for 1 cycle.
REQ-046 1R1T: samples (d1,q1)=(5,6) then (7,8) -> tdata=64'h0008_0007_0006_0005.
REQ-047 PKT_LEN=4, 9 words -> tlast on words 4 and 8 only.
REQ-048 tready=0, 17 words with FIFO_DEPTH=16 -> fifo_level=16, overflow=1, drop_cnt=1; on release, 16 words emerge in order.
REQ-049 2R2T orphan ch2, then ch1, ch1, ch2 -> drop_cnt=2 and one word containing the second ch1.
REQ-050 Reset asserted with 3 words queued and half a word pending -> all outputs 0 on the next cycle, and no stale word after reset release.
